parking_gate_ctrl: RTL and testbench

//  Downstream consumer of the debouncer outputs: takes the debounced entry button, exit button
//  and car-passed sensor levels and drives one barrier gate. Tracks lot occupancy 0..CAPACITY.
//  A gate FSM opens for one car per request and closes after a hold time.

---
 rtl/parking_gate_ctrl.sv | 162 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: edge-detects debounced entry/exit/pass levels, runs the gate FSM
// and tracks occupancy. Optional open-gate timeout is enabled by defining PARK_TIMEOUT_EN.
module parking_gate_ctrl #(
   parameter int CAPACITY     = 8,
   parameter int CNT_W        = 4,
   parameter int OPEN_CYCLES  = 50_000_000,
   parameter int CLOSE_CYCLES = 10_000_000,
   parameter int TIMER_W      = 26
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             entryBtn,
   input  logic             exitBtn,
   input  logic             passSensor,
   output logic             gateOpen,
   output logic [CNT_W-1:0] occupancy,
   output logic [CNT_W-1:0] freeSlots,
   output logic             full,
   output logic             empty,
   output logic             reject,
   output logic             timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_IN_OPEN,
      S_OUT_OPEN,
      S_CLOSE
   } state_t;

   localparam logic [CNT_W-1:0]   LP_CAP        = CNT_W'(CAPACITY);
   localparam logic [TIMER_W-1:0] LP_OPEN_LAST  = TIMER_W'(OPEN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LP_CLOSE_LAST = TIMER_W'(CLOSE_CYCLES - 1);

   state_t             r_state;
   logic               r_gate_open;
   logic [CNT_W-1:0]   r_occupancy;
   logic               r_reject;
   logic [TIMER_W-1:0] r_timer;
   logic               r_entry_prev;
   logic               r_exit_prev;
   logic               r_pass_prev;

   logic w_entry_rise;
   logic w_exit_rise;
   logic w_pass_rise;
   logic w_full;
   logic w_empty;

   assign w_entry_rise = entryBtn & ~r_entry_prev;
   assign w_exit_rise  = exitBtn & ~r_exit_prev;
   assign w_pass_rise  = passSensor & ~r_pass_prev;
   assign w_full       = (r_occupancy == LP_CAP);
   assign w_empty      = (r_occupancy == '0);

   // NOTE: history resets to 1 so a level already high when rst_n releases is not seen as a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_entry_prev <= 1'b1;
         r_exit_prev  <= 1'b1;
         r_pass_prev  <= 1'b1;
      end else begin
         r_entry_prev <= entryBtn;
         r_exit_prev  <= exitBtn;
         r_pass_prev  <= passSensor;
      end
   end

`ifdef PARK_TIMEOUT_EN
   logic r_timeout;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gate_open <= 1'b0;
         r_occupancy <= '0;
         r_reject    <= 1'b0;
         r_timer     <= '0;
`ifdef PARK_TIMEOUT_EN
         r_timeout   <= 1'b0;
`endif
      end else begin
         r_reject  <= 1'b0;
`ifdef PARK_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               r_timer <= '0;
               // Exit wins a simultaneous request; the losing entry is silently dropped.
               if (w_exit_rise) begin
                  if (w_empty) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_state     <= S_OUT_OPEN;
                     r_gate_open <= 1'b1;
                  end
               end else if (w_entry_rise) begin
                  if (w_full) begin
                     r_reject <= 1'b1;
                  end else begin
                     r_state     <= S_IN_OPEN;
                     r_gate_open <= 1'b1;
                  end
               end
            end

            S_IN_OPEN, S_OUT_OPEN: begin
               if (w_pass_rise) begin
                  if (r_state == S_IN_OPEN && !w_full) begin
                     r_occupancy <= r_occupancy + 1'b1;
                  end else if (r_state == S_OUT_OPEN && !w_empty) begin
                     r_occupancy <= r_occupancy - 1'b1;
                  end
                  r_state     <= S_CLOSE;
                  r_gate_open <= 1'b0;
                  r_timer     <= '0;
`ifdef PARK_TIMEOUT_EN
               end else if (r_timer == LP_OPEN_LAST) begin
                  r_state     <= S_CLOSE;
                  r_gate_open <= 1'b0;
                  r_timer     <= '0;
                  r_timeout   <= 1'b1;
`endif
               end else if (r_timer != LP_OPEN_LAST) begin
                  // Open-time counter saturates; only the timeout build acts on it.
                  r_timer <= r_timer + 1'b1;
               end
            end

            S_CLOSE: begin
               if (r_timer == LP_CLOSE_LAST) begin
                  r_state <= S_IDLE;
                  r_timer <= '0;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end

            default: begin
               r_state     <= S_IDLE;
               r_gate_open <= 1'b0;
               r_timer     <= '0;
            end
         endcase
      end
   end

   assign gateOpen  = r_gate_open;
   assign occupancy = r_occupancy;
   assign freeSlots = LP_CAP - r_occupancy;
   assign full      = w_full;
   assign empty     = w_empty;
   assign reject    = r_reject;
`ifdef PARK_TIMEOUT_EN
   assign timeout   = r_timeout;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios followed by random stimulus,
// all compared against a behavioural lot/gate model.
module tb_parking_gate_ctrl;

   localparam int CAP   = 3;
   localparam int CNT_W = 2;
   localparam int OPEN  = 20;
   localparam int CLOSE = 4;

   logic             clk;
   logic             rst_n;
   logic             entryBtn;
   logic             exitBtn;
   logic             passSensor;
   logic             gateOpen;
   logic [CNT_W-1:0] occupancy;
   logic [CNT_W-1:0] freeSlots;
   logic             full;
   logic             empty;
   logic             reject;
   logic             timeout;

   parking_gate_ctrl #(
      .CAPACITY    (CAP),
      .CNT_W       (CNT_W),
      .OPEN_CYCLES (OPEN),
      .CLOSE_CYCLES(CLOSE),
      .TIMER_W     (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .entryBtn  (entryBtn),
      .exitBtn   (exitBtn),
      .passSensor(passSensor),
      .gateOpen  (gateOpen),
      .occupancy (occupancy),
      .freeSlots (freeSlots),
      .full      (full),
      .empty     (empty),
      .reject    (reject),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: cars in the lot, whether the barrier is up and which way the car goes,
   // remaining closing cycles and how long the barrier has been up.
   int m_occ;
   bit m_up;
   int m_dir;
   int m_close_left;
   int m_open_age;
   bit m_rej;
   bit m_to;
   bit m_pe, m_px, m_pp;
   bit cur_e, cur_x, cur_p;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_occ = 0; m_up = 0; m_dir = 0; m_close_left = 0; m_open_age = 0;
      m_rej = 0; m_to = 0;
      m_pe = 1; m_px = 1; m_pp = 1;
   endtask

   task automatic model_edge(input bit e, input bit x, input bit p);
      bit er, xr, pr;
      er = e & !m_pe; xr = x & !m_px; pr = p & !m_pp;
      m_pe = e; m_px = x; m_pp = p;
      m_rej = 0;
      m_to  = 0;
      if (m_close_left > 0) begin
         m_close_left--;
      end else if (m_up) begin
         if (pr) begin
            m_occ = m_occ + m_dir;
            if (m_occ > CAP) m_occ = CAP;
            if (m_occ < 0) m_occ = 0;
            m_up = 0;
            m_close_left = CLOSE;
         end else begin
            m_open_age++;
`ifdef PARK_TIMEOUT_EN
            if (m_open_age == OPEN) begin
               m_up = 0;
               m_to = 1;
               m_close_left = CLOSE;
            end
`endif
         end
      end else if (xr) begin
         if (m_occ == 0) m_rej = 1;
         else begin m_up = 1; m_dir = -1; m_open_age = 0; end
      end else if (er) begin
         if (m_occ == CAP) m_rej = 1;
         else begin m_up = 1; m_dir = 1; m_open_age = 0; end
      end
   endtask

   task automatic check_all();
      check("gateOpen",  gateOpen,  m_up);
      check("occupancy", occupancy, m_occ);
      check("freeSlots", freeSlots, CAP - m_occ);
      check("full",      full,      m_occ == CAP);
      check("empty",     empty,     m_occ == 0);
      check("reject",    reject,    m_rej);
      check("timeout",   timeout,   m_to);
   endtask

   // Drive levels just after a falling edge, update the model at the rising edge, compare at the next falling edge.
   task automatic step(input bit e, input bit x, input bit p);
      cur_e = e; cur_x = x; cur_p = p;
      entryBtn = e; exitBtn = x; passSensor = p;
      @(posedge clk);
      model_edge(e, x, p);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   task automatic car_in();
      step(0, 0, 0); step(1, 0, 0); step(1, 0, 1); idle_steps(CLOSE);
   endtask

   task automatic car_out();
      step(0, 0, 0); step(0, 1, 0); step(0, 1, 1); idle_steps(CLOSE);
   endtask

   // Asynchronous reset away from the clock edge; outputs must clear before any edge.
   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_gate", gateOpen, 0);
      check("rst_occ",  occupancy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Entry held high through reset must not open the gate.
      rst_n = 1'b0; entryBtn = 1'b1; exitBtn = 1'b0; passSensor = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      check("t1_gate",  gateOpen, 0);
      check("t1_empty", empty, 1);

      // Entry, pass five cycles later, entry rise during closing ignored.
      step(0, 0, 0);
      step(1, 0, 0);
      check("t2_open", gateOpen, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0);
      step(1, 0, 1);
      check("t2_occ",  occupancy, 1);
      check("t2_shut", gateOpen, 0);
      step(0, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
      check("t2_close_ignore", gateOpen, 0);
      step(0, 0, 0);

      // Fill the lot, then one more entry is refused.
      car_in(); car_in();
      step(0, 0, 0);
      step(1, 0, 0);
      check("t3_full",   full, 1);
      check("t3_free",   freeSlots, 0);
      check("t3_reject", reject, 1);
      check("t3_gate",   gateOpen, 0);
      step(0, 0, 0);
      check("t3_reject_pulse", reject, 0);

      // Simultaneous entry and exit: exit wins, no reject.
      car_out();
      step(0, 0, 0);
      step(1, 1, 0);
      check("t4_reject", reject, 0);
      check("t4_gate",   gateOpen, 1);
      step(1, 1, 1);
      check("t4_occ", occupancy, 1);
      idle_steps(CLOSE);

      // Exit on an empty lot is refused.
      car_out();
      step(0, 0, 0);
      step(0, 1, 0);
      check("t5_reject", reject, 1);
      check("t5_occ",    occupancy, 0);
      check("t5_gate",   gateOpen, 0);
      step(0, 0, 0);

      // Entry with no car passing.
      step(1, 0, 0);
`ifdef PARK_TIMEOUT_EN
      for (int i = 0; i < OPEN - 1; i++) step(1, 0, 0);
      check("t6_still_open", gateOpen, 1);
      step(1, 0, 0);
      check("t6_timeout", timeout, 1);
      check("t6_gate",    gateOpen, 0);
      check("t6_occ",     occupancy, 0);
`else
      for (int i = 0; i < 100; i++) step(1, 0, 0);
      check("t6_open_wait", gateOpen, 1);
`endif
      step(1, 0, 1);
      idle_steps(CLOSE + 1);

      // Reset while the gate is up.
      step(0, 0, 0);
      step(1, 0, 0);
      mid_reset();
      step(1, 0, 0);
      check("t7_no_refire", gateOpen, 0);

      // Random level toggling with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            mid_reset();
         end else begin
            step(cur_e ^ ($urandom_range(0, 3) == 0),
                 cur_x ^ ($urandom_range(0, 4) == 0),
                 cur_p ^ ($urandom_range(0, 2) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
